// File: rtl/bp_pkg.sv
// Shared types and encodings for the branch prediction controller.
package bp_pkg;

    localparam int unsigned BP_ENTRIES = 16;
    localparam int unsigned BP_PC_W    = 32;

    // PC-mux select encodings
    localparam logic [1:0] MUXPC_SEQ      = 2'd0;
    localparam logic [1:0] MUXPC_PRED     = 2'd1;
    localparam logic [1:0] MUXPC_RECOV_NT = 2'd2;
    localparam logic [1:0] MUXPC_RECOV_T  = 2'd3;

    // 2-bit saturating counter values
    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    // Table entry; tag field is sized to the full PC so any ENTRIES/PC_W fits.
    typedef struct packed {
        logic               valid;
        logic [BP_PC_W-1:0] tag;
        logic [BP_PC_W-1:0] target;
        logic [1:0]         cnt;
    } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter, combinational.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] cnt_next_c
);

    // Step toward taken or not-taken, holding at the rails.
    always_comb begin
        cnt_next_c = cnt;
        if (inc) begin
            if (cnt != CNT_ST) cnt_next_c = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) cnt_next_c = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction table controller: IF lookup, EX mispredict recovery,
// one-deep update register and post-reset valid-clear sweep.
// Optional macro BP_WRITE_BYPASS_EN forwards the pending update to lookups.
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = BP_ENTRIES,
    parameter int unsigned PC_W    = BP_PC_W
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_hit,
    output logic            if_pred,
    output logic [PC_W-1:0] if_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_hit,
    input  logic            ex_pred,
    output logic [1:0]      mux_pc,
    output logic            flush,
    output logic            wr_busy
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    bp_entry_t        tbl [ENTRIES];
    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] init_idx_q;

    logic             upd_valid_q;
    logic [IDX_W-1:0] upd_idx_q;
    logic [TAG_W-1:0] upd_tag_q;
    logic             upd_taken_q;
    logic [PC_W-1:0]  upd_target_q;
    logic             upd_hit_q;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    bp_entry_t        wr_old, wr_entry, lk_entry, ex_entry;
    logic             wr_en, tag_ok, ex_tgt_ok, mispredict;
    logic [1:0]       cnt_next;
    logic             unused_pc_lsbs;

    assign if_idx         = if_pc[IDX_W+1:2];
    assign if_tag         = if_pc[PC_W-1:IDX_W+2];
    assign ex_idx         = ex_pc[IDX_W+1:2];
    assign ex_tag         = ex_pc[PC_W-1:IDX_W+2];
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    assign ready   = (state_q == RUN);
    assign wr_busy = upd_valid_q;

    assign wr_old = tbl[upd_idx_q];

    bp_sat_counter u_cnt (
        .cnt        (wr_old.cnt),
        .inc        (upd_taken_q),
        .cnt_next_c (cnt_next)
    );

    // Resolve the pending update against the entry as it stands now (tag recheck).
    always_comb begin
        tag_ok   = wr_old.valid && (wr_old.tag == BP_PC_W'(upd_tag_q));
        wr_entry = wr_old;
        wr_en    = 1'b0;
        if (upd_valid_q && (state_q == RUN) && !rst) begin
            if (upd_hit_q && tag_ok) begin
                wr_en        = 1'b1;
                wr_entry.cnt = cnt_next;
                if (upd_taken_q) wr_entry.target = BP_PC_W'(upd_target_q);
            end else if (upd_taken_q) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = BP_PC_W'(upd_tag_q);
                wr_entry.target = BP_PC_W'(upd_target_q);
                wr_entry.cnt    = CNT_WT;
            end
        end
    end

    // Table storage: clear sweep in INIT, single update write port in RUN.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            tbl[init_idx_q].valid <= 1'b0;
        end else if (wr_en) begin
            tbl[upd_idx_q] <= wr_entry;
        end
    end

    // Lookup entry, optionally forwarded from the pending write.
    always_comb begin
        lk_entry = tbl[if_idx];
`ifdef BP_WRITE_BYPASS_EN
        if (wr_en && (upd_idx_q == if_idx)) lk_entry = wr_entry;
`else
        lk_entry = tbl[if_idx];
`endif
    end

    // Fetch-side hit, prediction and target.
    always_comb begin
        if_hit    = 1'b0;
        if_pred   = 1'b0;
        if_target = '0;
        if ((state_q == RUN) && lk_entry.valid && (lk_entry.tag == BP_PC_W'(if_tag))) begin
            if_hit    = 1'b1;
            if_pred   = lk_entry.cnt[1];
            if_target = PC_W'(lk_entry.target);
        end
    end

    // Direction mismatch, or predicted-taken with a stale stored target.
    always_comb begin
        ex_entry   = tbl[ex_idx];
        ex_tgt_ok  = ex_entry.valid && (ex_entry.tag == BP_PC_W'(ex_tag))
                     && (ex_entry.target == BP_PC_W'(ex_target));
        mispredict = (ex_pred != ex_taken) || (ex_pred && ex_taken && !ex_tgt_ok);
    end

    // Next-state and PC-mux/flush decode.
    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        mux_pc  = MUXPC_SEQ;
        case (state_q)
            INIT: begin
                if (init_idx_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
            end
            RUN: begin
                if (ex_valid && mispredict) begin
                    flush  = 1'b1;
                    mux_pc = ex_taken ? MUXPC_RECOV_T : MUXPC_RECOV_NT;
                end else if (if_hit && if_pred) begin
                    mux_pc = MUXPC_PRED;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State, sweep index and update register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT;
            init_idx_q   <= '0;
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= '0;
            upd_tag_q    <= '0;
            upd_taken_q  <= 1'b0;
            upd_target_q <= '0;
            upd_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (state_q == INIT) init_idx_q <= init_idx_q + IDX_W'(1);
            upd_valid_q <= ex_valid && (state_q == RUN);
            if (ex_valid && (state_q == RUN)) begin
                upd_idx_q    <= ex_idx;
                upd_tag_q    <= ex_tag;
                upd_taken_q  <= ex_taken;
                upd_target_q <= ex_target;
                upd_hit_q    <= ex_hit;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed self-checking bench for branch_predict_ctrl (ENTRIES = 16, PC_W = 32).
module tb_branch_predict_ctrl;
    import bp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] if_pc;
    logic        if_hit;
    logic        if_pred;
    logic [31:0] if_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_hit;
    logic        ex_pred;
    logic [1:0]  mux_pc;
    logic        flush;
    logic        wr_busy;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predict_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .if_pc     (if_pc),
        .if_hit    (if_hit),
        .if_pred   (if_pred),
        .if_target (if_target),
        .ex_valid  (ex_valid),
        .ex_pc     (ex_pc),
        .ex_taken  (ex_taken),
        .ex_target (ex_target),
        .ex_hit    (ex_hit),
        .ex_pred   (ex_pred),
        .mux_pc    (mux_pc),
        .flush     (flush),
        .wr_busy   (wr_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ex();
        ex_valid  = 1'b0;
        ex_pc     = '0;
        ex_taken  = 1'b0;
        ex_target = '0;
        ex_hit    = 1'b0;
        ex_pred   = 1'b0;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                            input logic hit, input logic pred);
        ex_valid  = 1'b1;
        ex_pc     = pc;
        ex_taken  = taken;
        ex_target = tgt;
        ex_hit    = hit;
        ex_pred   = pred;
    endtask

    // One isolated update: latch, then write, ending with the table updated.
    task automatic upd_once(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                            input logic hit, input logic pred);
        drive_ex(pc, taken, tgt, hit, pred);
        step();
        idle_ex();
        step();
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                          input logic pred, input logic [31:0] tgt, input logic [1:0] mux);
        if_pc = pc;
        #1;
        chk({tag, "_hit"},    32'(if_hit),    32'(hit));
        chk({tag, "_pred"},   32'(if_pred),   32'(pred));
        chk({tag, "_target"}, if_target,      tgt);
        chk({tag, "_mux"},    32'(mux_pc),    32'(mux));
    endtask

    initial begin
        rst   = 1'b1;
        if_pc = '0;
        idle_ex();
        step();
        rst = 1'b0;

        // Reset state and clear sweep; ex_valid during INIT must be ignored.
        chk("rst_ready",   32'(ready),   32'd0);
        chk("rst_wr_busy", 32'(wr_busy), 32'd0);
        chk("rst_flush",   32'(flush),   32'd0);
        lookup("init", 32'h40, 1'b0, 1'b0, 32'h0, MUXPC_SEQ);
        drive_ex(32'h4C, 1'b1, 32'h800, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            step();
            if_pc = 32'h40;
            #1;
            chk("init_ready", 32'(ready),  32'd0);
            chk("init_hit",   32'(if_hit), 32'd0);
            chk("init_flush", 32'(flush),  32'd0);
            if (i == 15) idle_ex();
        end
        step();
        chk("ready_up", 32'(ready),   32'd1);
        chk("init_wr",  32'(wr_busy), 32'd0);
        lookup("init_ign", 32'h4C, 1'b0, 1'b0, 32'h0, MUXPC_SEQ);

        // Allocation on miss & taken.
        if_pc = 32'h40;
        drive_ex(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        #1;
        chk("alloc_flush", 32'(flush),  32'd1);
        chk("alloc_mux",   32'(mux_pc), 32'(MUXPC_RECOV_T));
        step();
        idle_ex();
        #1;
        chk("alloc_busy", 32'(wr_busy), 32'd1);
`ifdef BP_WRITE_BYPASS_EN
        chk("alloc_byp_hit", 32'(if_hit), 32'd1);
        chk("alloc_byp_tgt", if_target,   32'h100);
`else
        chk("alloc_late_hit", 32'(if_hit), 32'd0);
`endif
        step();
        lookup("alloc", 32'h40, 1'b1, 1'b1, 32'h100, MUXPC_PRED);
        chk("alloc_idle", 32'(wr_busy), 32'd0);

        // Five back-to-back taken updates saturate at strongly taken.
        if_pc = 32'h40;
        for (int i = 0; i < 5; i++) begin
            drive_ex(32'h40, 1'b1, 32'h100, 1'b1, 1'b1);
            #1;
            chk("sat_noflush", 32'(flush),  32'd0);
            chk("sat_mux",     32'(mux_pc), 32'(MUXPC_PRED));
            step();
        end
        idle_ex();
        step();
        lookup("sat_st", 32'h40, 1'b1, 1'b1, 32'h100, MUXPC_PRED);

        // Not-taken walk down: 11 -> 10 -> 01 -> 00 -> 00, then back up.
        drive_ex(32'h40, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        chk("nt1_flush", 32'(flush),  32'd1);
        chk("nt1_mux",   32'(mux_pc), 32'(MUXPC_RECOV_NT));
        step();
        idle_ex();
        step();
        lookup("nt1", 32'h40, 1'b1, 1'b1, 32'h100, MUXPC_PRED);
        upd_once(32'h40, 1'b0, 32'h0, 1'b1, 1'b1);
        lookup("nt2", 32'h40, 1'b1, 1'b0, 32'h100, MUXPC_SEQ);
        upd_once(32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        upd_once(32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
        upd_once(32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        lookup("sat_floor", 32'h40, 1'b1, 1'b0, 32'h100, MUXPC_SEQ);
        upd_once(32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        lookup("up_wt", 32'h40, 1'b1, 1'b1, 32'h100, MUXPC_PRED);

        // Predicted taken with wrong target: recover and rewrite target.
        drive_ex(32'h40, 1'b1, 32'h180, 1'b1, 1'b1);
        #1;
        chk("tgt_flush", 32'(flush),  32'd1);
        chk("tgt_mux",   32'(mux_pc), 32'(MUXPC_RECOV_T));
        step();
        idle_ex();
        step();
        lookup("tgt_new", 32'h40, 1'b1, 1'b1, 32'h180, MUXPC_PRED);

        // Aliasing: 0x80 shares index 0 with 0x40.
        upd_once(32'h80, 1'b1, 32'h300, 1'b0, 1'b0);
        lookup("alias_old", 32'h40, 1'b0, 1'b0, 32'h0, MUXPC_SEQ);
        lookup("alias_new", 32'h80, 1'b1, 1'b1, 32'h300, MUXPC_PRED);

        // Not-taken recovery overrides a simultaneous predicted fetch hit.
        if_pc = 32'h80;
        drive_ex(32'h200, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        chk("ntr_flush",  32'(flush),  32'd1);
        chk("ntr_mux",    32'(mux_pc), 32'(MUXPC_RECOV_NT));
        chk("ntr_if_hit", 32'(if_hit), 32'd1);
        step();
        idle_ex();
        step();
        lookup("ntr_keep",  32'h80,  1'b1, 1'b1, 32'h300, MUXPC_PRED);
        lookup("ntr_noalc", 32'h200, 1'b0, 1'b0, 32'h0,   MUXPC_SEQ);

        // Back-to-back updates on consecutive cycles are both written.
        drive_ex(32'h44, 1'b1, 32'h500, 1'b0, 1'b0);
        step();
        drive_ex(32'h48, 1'b1, 32'h600, 1'b0, 1'b0);
        #1;
        chk("b2b_busy1", 32'(wr_busy), 32'd1);
        step();
        idle_ex();
        #1;
        chk("b2b_busy2", 32'(wr_busy), 32'd1);
        step();
        lookup("b2b_a", 32'h44, 1'b1, 1'b1, 32'h500, MUXPC_PRED);
        lookup("b2b_b", 32'h48, 1'b1, 1'b1, 32'h600, MUXPC_PRED);

        // Tag recheck: not-taken hit-update to a reallocated entry is dropped.
        drive_ex(32'hC4, 1'b1, 32'h700, 1'b0, 1'b0);
        step();
        drive_ex(32'h44, 1'b0, 32'h0, 1'b1, 1'b1);
        step();
        idle_ex();
        step();
        lookup("rchk_nt_keep", 32'hC4, 1'b1, 1'b1, 32'h700, MUXPC_PRED);
        lookup("rchk_nt_old",  32'h44, 1'b0, 1'b0, 32'h0,   MUXPC_SEQ);

        // Tag recheck: taken hit-update to a reallocated entry allocates.
        drive_ex(32'hC8, 1'b1, 32'h900, 1'b0, 1'b0);
        step();
        drive_ex(32'h48, 1'b1, 32'h650, 1'b1, 1'b1);
        step();
        idle_ex();
        step();
        lookup("rchk_t_alloc", 32'h48, 1'b1, 1'b1, 32'h650, MUXPC_PRED);
        lookup("rchk_t_evict", 32'hC8, 1'b0, 1'b0, 32'h0,   MUXPC_SEQ);

        // Reset with an update pending: discarded, table swept.
        drive_ex(32'h4C, 1'b1, 32'h800, 1'b0, 1'b0);
        step();
        idle_ex();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rrst_ready", 32'(ready),   32'd0);
        chk("rrst_busy",  32'(wr_busy), 32'd0);
        for (int i = 0; i < 16; i++) step();
        chk("rrst_ready_up", 32'(ready), 32'd1);
        lookup("rrst_miss",  32'h4C, 1'b0, 1'b0, 32'h0, MUXPC_SEQ);
        lookup("rrst_clear", 32'h48, 1'b0, 1'b0, 32'h0, MUXPC_SEQ);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
